// File: rtl/reg_writeback.sv
// Writeback arbiter: merges the single-cycle port A stream with a FIFO-buffered port B
// stream onto the register-file write port. Optional B bypass: REG_WB_BYPASS_EN.
module reg_writeback #(
   parameter int DataWidth    = 32,
   parameter int AddrRegWidth = 5,
   parameter int Depth        = 4
) (
   input  logic                       brq_clk,
   input  logic                       brq_rst_n,
   input  logic                       a_valid,
   input  logic [AddrRegWidth-1:0]    a_rd,
   input  logic [DataWidth-1:0]       a_data,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [AddrRegWidth-1:0]    b_rd,
   input  logic [DataWidth-1:0]       b_data,
   input  logic [AddrRegWidth-1:0]    source1,
   input  logic [AddrRegWidth-1:0]    source2,
   output logic                       pending1,
   output logic                       pending2,
   output logic                       writeEn,
   output logic [AddrRegWidth-1:0]    writeDataSel,
   output logic [DataWidth-1:0]       writeData,
   output logic [$clog2(Depth+1)-1:0] fifo_count
);

   localparam int PW = $clog2(Depth);
   localparam int CW = $clog2(Depth+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

   typedef struct packed {
      logic                    vld;
      logic [AddrRegWidth-1:0] rd;
      logic [DataWidth-1:0]    data;
   } ent_t;

   ent_t                    ent_q [Depth];
   ent_t                    ent_d [Depth];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    we_q, we_d;
   logic [AddrRegWidth-1:0] sel_q, sel_d;
   logic [DataWidth-1:0]    wdata_q, wdata_d;

   logic a_wr, b_fire, b_nz, pop, push, bypass;
   logic hit1, hit2;

   assign a_wr    = a_valid && (a_rd != '0);
   // a full FIFO never grants ready, even when it pops this cycle
   assign b_ready = brq_rst_n && (count_q < DEPTH_C);
   assign b_fire  = b_valid && b_ready;
   assign b_nz    = b_fire && (b_rd != '0);
   assign pop     = !a_wr && (count_q != '0);

`ifdef REG_WB_BYPASS_EN
   assign bypass  = !a_wr && (count_q == '0) && b_nz;
`else
   assign bypass  = 1'b0;
`endif

   assign push    = b_nz && !bypass;

   always_comb begin
      ent_d    = ent_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         ent_d[wr_ptr_q] = '{vld: 1'b1, rd: b_rd, data: b_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         ent_d[rd_ptr_q].vld = 1'b0;
         rd_ptr_d            = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      we_d    = 1'b0;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      if (a_wr) begin
         we_d    = 1'b1;
         sel_d   = a_rd;
         wdata_d = a_data;
      end else if (pop) begin
         we_d    = 1'b1;
         sel_d   = ent_q[rd_ptr_q].rd;
         wdata_d = ent_q[rd_ptr_q].data;
      end else if (bypass) begin
         we_d    = 1'b1;
         sel_d   = b_rd;
         wdata_d = b_data;
      end
   end

   always_ff @(posedge brq_clk) begin
      if (!brq_rst_n) begin
         for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         wdata_q  <= '0;
      end else begin
         for (int i = 0; i < Depth; i++) ent_q[i] <= ent_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
      end
   end

   // Pending covers queued entries plus the result sitting in the output stage
   always_comb begin
      hit1 = we_q && (sel_q == source1);
      hit2 = we_q && (sel_q == source2);
      for (int i = 0; i < Depth; i++) begin
         hit1 = hit1 | (ent_q[i].vld && (ent_q[i].rd == source1));
         hit2 = hit2 | (ent_q[i].vld && (ent_q[i].rd == source2));
      end
   end

   assign pending1     = brq_rst_n && (source1 != '0) && hit1;
   assign pending2     = brq_rst_n && (source2 != '0) && hit2;
   assign writeEn      = we_q;
   assign writeDataSel = sel_q;
   assign writeData    = wdata_q;
   assign fifo_count   = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: vector table plus hand sequences for reset,
// B latency, backpressure and mid-operation reset.
module tb_reg_writeback;

   logic        brq_clk = 1'b0;
   logic        brq_rst_n;
   logic        a_valid, b_valid, b_ready;
   logic [4:0]  a_rd, b_rd, source1, source2, writeDataSel;
   logic [31:0] a_data, b_data, writeData;
   logic        pending1, pending2, writeEn;
   logic [2:0]  fifo_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 brq_clk = ~brq_clk;

   reg_writeback #(.DataWidth(32), .AddrRegWidth(5), .Depth(4)) dut (
      .brq_clk(brq_clk), .brq_rst_n(brq_rst_n),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .source1(source1), .source2(source2),
      .pending1(pending1), .pending2(pending2),
      .writeEn(writeEn), .writeDataSel(writeDataSel), .writeData(writeData),
      .fifo_count(fifo_count)
   );

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] adata;
      logic        bv;  logic [4:0] brd; logic [31:0] bdata;
      logic [4:0]  s1;  logic [4:0] s2;
      logic        we;  logic [4:0] sel; logic [31:0] data;
      logic [2:0]  cnt; logic       brdy; logic p1; logic p2;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge brq_clk);
      #1;
   endtask

   task automatic idle_in();
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
   endtask

   initial begin
      //        av ard adata         bv brd bdata   s1  s2  we sel data          cnt brdy p1 p2
      vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,      5,  0,  1, 5,  32'hDEADBEEF, 0, 1, 1, 0};
      vecs[1]  = '{1, 3, 32'h33,       1, 9, 32'h99, 9,  3,  1, 3,  32'h33,       1, 1, 1, 1};
      vecs[2]  = '{1, 0, 32'h55,       0, 0, 0,      9,  0,  1, 9,  32'h99,       0, 1, 1, 0};
      vecs[3]  = '{0, 0, 0,            0, 0, 0,      9,  0,  0, 9,  32'h99,       0, 1, 0, 0};
      vecs[4]  = '{1, 4, 32'h44,       1, 0, 32'hFF, 0,  4,  1, 4,  32'h44,       0, 1, 0, 1};
      vecs[5]  = '{0, 0, 0,            0, 0, 0,      4,  4,  0, 4,  32'h44,       0, 1, 0, 0};
      vecs[6]  = '{1, 6, 32'h66,       1, 10,32'hA0, 10, 6,  1, 6,  32'h66,       1, 1, 1, 1};
      vecs[7]  = '{1, 6, 32'h67,       1, 11,32'hB0, 10, 11, 1, 6,  32'h67,       2, 1, 1, 1};
      vecs[8]  = '{0, 0, 0,            0, 0, 0,      10, 11, 1, 10, 32'hA0,       1, 1, 1, 1};
      vecs[9]  = '{0, 0, 0,            1, 12,32'hC0, 11, 12, 1, 11, 32'hB0,       1, 1, 1, 1};
      vecs[10] = '{0, 0, 0,            0, 0, 0,      11, 12, 1, 12, 32'hC0,       0, 1, 0, 1};
      vecs[11] = '{0, 0, 0,            0, 0, 0,      11, 12, 0, 12, 32'hC0,       0, 1, 0, 0};

      // reset held with a_valid asserted
      idle_in();
      brq_rst_n = 0; a_valid = 1; a_rd = 5; a_data = 32'h1234;
      source1 = 5; source2 = 5;
      tick(); tick();
      chk("rst_we",    32'(writeEn), 0);
      chk("rst_cnt",   32'(fifo_count), 0);
      chk("rst_bready",32'(b_ready), 0);
      chk("rst_pend1", 32'(pending1), 0);
      chk("rst_sel",   32'(writeDataSel), 0);
      chk("rst_data",  writeData, 0);
      brq_rst_n = 1; idle_in();
      #1;
      chk("rel_bready", 32'(b_ready), 1);

      // table
      for (int i = 0; i < 12; i++) begin
         a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].adata;
         b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bdata;
         source1 = vecs[i].s1; source2 = vecs[i].s2;
         tick();
         chk($sformatf("v%0d_we", i),    32'(writeEn),      32'(vecs[i].we));
         chk($sformatf("v%0d_sel", i),   32'(writeDataSel), 32'(vecs[i].sel));
         chk($sformatf("v%0d_data", i),  writeData,         vecs[i].data);
         chk($sformatf("v%0d_cnt", i),   32'(fifo_count),   32'(vecs[i].cnt));
         chk($sformatf("v%0d_bready", i),32'(b_ready),      32'(vecs[i].brdy));
         chk($sformatf("v%0d_p1", i),    32'(pending1),     32'(vecs[i].p1));
         chk($sformatf("v%0d_p2", i),    32'(pending2),     32'(vecs[i].p2));
      end

      // B latency into an empty FIFO
      idle_in(); source1 = 7; source2 = 0;
      b_valid = 1; b_rd = 7; b_data = 32'h11;
      tick();
      b_valid = 0;
`ifdef REG_WB_BYPASS_EN
      chk("lat_t1_we",  32'(writeEn), 1);
      chk("lat_t1_sel", 32'(writeDataSel), 7);
      chk("lat_t1_cnt", 32'(fifo_count), 0);
      tick();
      chk("lat_t2_we",  32'(writeEn), 0);
      chk("lat_t2_cnt", 32'(fifo_count), 0);
`else
      chk("lat_t1_we",  32'(writeEn), 0);
      chk("lat_t1_cnt", 32'(fifo_count), 1);
      chk("lat_t1_p1",  32'(pending1), 1);
      tick();
      chk("lat_t2_we",  32'(writeEn), 1);
      chk("lat_t2_sel", 32'(writeDataSel), 7);
      chk("lat_t2_data",writeData, 32'h11);
      chk("lat_t2_cnt", 32'(fifo_count), 0);
`endif
      tick();
      chk("lat_end_we", 32'(writeEn), 0);
      chk("lat_end_p1", 32'(pending1), 0);

      // backpressure: A writes rd3 every cycle, B offers rd1..5
      idle_in(); source1 = 0; source2 = 0;
      a_valid = 1; a_rd = 3; a_data = 32'h3;
      for (int k = 1; k <= 4; k++) begin
         b_valid = 1; b_rd = 5'(k); b_data = 32'(k * 16);
         #1;
         chk($sformatf("bp_ready%0d", k), 32'(b_ready), 1);
         tick();
         chk($sformatf("bp_wr_a%0d", k), 32'(writeDataSel), 3);
      end
      b_rd = 5; b_data = 32'h50;
      tick();
      chk("bp_full_cnt",   32'(fifo_count), 4);
      chk("bp_full_ready", 32'(b_ready), 0);
      a_valid = 0;
      tick();
      chk("bp_d1_sel", 32'(writeDataSel), 1);
      chk("bp_d1_cnt", 32'(fifo_count), 3);
      chk("bp_d1_rdy", 32'(b_ready), 1);
      tick();
      b_valid = 0;
      chk("bp_d2_sel", 32'(writeDataSel), 2);
      chk("bp_d2_cnt", 32'(fifo_count), 3);
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk($sformatf("bp_d%0d_we", k),   32'(writeEn), 1);
         chk($sformatf("bp_d%0d_sel", k),  32'(writeDataSel), 32'(k));
         chk($sformatf("bp_d%0d_data", k), writeData, 32'(k * 16));
      end
      chk("bp_empty", 32'(fifo_count), 0);

      // mid-operation reset drops queued results
      a_valid = 1; a_rd = 2; a_data = 32'h2;
      b_valid = 1; b_rd = 8; b_data = 32'h88;
      tick(); tick();
      chk("mr_cnt_pre", 32'(fifo_count), 2);
      brq_rst_n = 0;
      tick();
      chk("mr_we",  32'(writeEn), 0);
      chk("mr_cnt", 32'(fifo_count), 0);
      brq_rst_n = 1; idle_in(); source1 = 8;
      tick();
      chk("mr_post_we",  32'(writeEn), 0);
      chk("mr_post_cnt", 32'(fifo_count), 0);
      chk("mr_post_p1",  32'(pending1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
